mem_arbiter: RTL and testbench

- Arbitrates a single shared memory port between the instruction-fetch requester (IF stage) and the data-access requester (MEM stage) of the 5-stage pipeline.
- Sequences each access as a request/acknowledge transaction and returns one-cycle ready pulses.
- Exposes stall signals that gate the PC, IF/ID and pipeline-register enables.
- Data accesses have priority over fetch, because the MEM-stage instruction is older.

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the IF-stage fetch requester and the
// MEM-stage data requester. Each access is one mem_req/mem_ack transaction that ends
// in a one-cycle ready pulse. Data wins over fetch because the MEM-stage instruction
// is older.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   if_req/if_addr              fetch request (held until if_ready) and PC
//   if_rdata/if_ready           fetched word and one-cycle completion pulse
//   d_read/d_write/d_addr/d_wdata  data request, address and store data
//   d_rdata/d_ready             load data and one-cycle completion pulse
//   stall_if/stall_mem          combinational pipeline stalls
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held stable until mem_ack
//   mem_rdata/mem_ack           memory read data and completion
//   err                         sticky: timeout or simultaneous read+write
//   conflict_cnt                saturating count of IDLE cycles with both requesters active
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err,
  output logic [15:0] conflict_cnt
);

  // Wait counter only needs to reach TIMEOUT-1; the abort fires on that edge.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StDBusy, StIfBusy, StResp} state_e;

  state_e          r_state, w_state_d;
  logic            r_mem_req, w_mem_req_d;
  logic            r_mem_we, w_mem_we_d;
  logic [31:0]     r_mem_addr, w_mem_addr_d;
  logic [31:0]     r_mem_wdata, w_mem_wdata_d;
  logic [31:0]     r_if_rdata, w_if_rdata_d;
  logic [31:0]     r_d_rdata, w_d_rdata_d;
  logic            r_if_ready, w_if_ready_d;
  logic            r_d_ready, w_d_ready_d;
  logic            r_err, w_err_d;
  logic [15:0]     r_conflict, w_conflict_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            w_d_any;
  logic            w_is_d;

  assign w_d_any = d_read | d_write;
  assign w_is_d  = (r_state == StDBusy);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d     = r_state;
    w_mem_req_d   = r_mem_req;
    w_mem_we_d    = r_mem_we;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_if_rdata_d  = r_if_rdata;
    w_d_rdata_d   = r_d_rdata;
    w_if_ready_d  = r_if_ready;
    w_d_ready_d   = r_d_ready;
    w_err_d       = r_err;
    w_conflict_d  = r_conflict;
    w_cnt_d       = r_cnt;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (w_d_any && if_req && (r_conflict != 16'hFFFF)) w_conflict_d = r_conflict + 16'd1;
        if (w_d_any) begin
          w_state_d     = StDBusy;
          w_mem_req_d   = 1'b1;
          w_mem_we_d    = d_write;  // read+write together resolves to a write
          w_mem_addr_d  = d_addr;
          w_mem_wdata_d = d_wdata;
          if (d_read && d_write) w_err_d = 1'b1;
        end else if (if_req) begin
          w_state_d    = StIfBusy;
          w_mem_req_d  = 1'b1;
          w_mem_we_d   = 1'b0;
          w_mem_addr_d = if_addr;
        end
      end
      StDBusy, StIfBusy: begin
        if (mem_ack) begin
          w_state_d   = StResp;
          w_mem_req_d = 1'b0;
          w_mem_we_d  = 1'b0;
          if (w_is_d) begin
            w_d_ready_d = 1'b1;
            if (!r_mem_we) w_d_rdata_d = mem_rdata;
          end else begin
            w_if_ready_d = 1'b1;
            w_if_rdata_d = mem_rdata;
          end
        end else if ((TIMEOUT != 0) && (r_cnt == CntLast)) begin
          w_state_d   = StResp;
          w_mem_req_d = 1'b0;
          w_mem_we_d  = 1'b0;
          w_err_d     = 1'b1;
          if (w_is_d) begin
            w_d_ready_d = 1'b1;
            w_d_rdata_d = ERR_DATA;
          end else begin
            w_if_ready_d = 1'b1;
            w_if_rdata_d = ERR_DATA;
          end
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StResp: begin
        // Requests are not sampled here so a still-held request is not reissued.
        w_state_d    = StIdle;
        w_if_ready_d = 1'b0;
        w_d_ready_d  = 1'b0;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
      r_err       <= 1'b0;
      r_conflict  <= '0;
      r_cnt       <= '0;
    end else begin
      r_mem_req   <= w_mem_req_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_if_rdata  <= w_if_rdata_d;
      r_d_rdata   <= w_d_rdata_d;
      r_if_ready  <= w_if_ready_d;
      r_d_ready   <= w_d_ready_d;
      r_err       <= w_err_d;
      r_conflict  <= w_conflict_d;
      r_cnt       <= w_cnt_d;
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign if_rdata     = r_if_rdata;
  assign if_ready     = r_if_ready;
  assign d_rdata      = r_d_rdata;
  assign d_ready      = r_d_ready;
  assign err          = r_err;
  assign conflict_cnt = r_conflict;
  assign stall_if     = if_req & ~r_if_ready;
  assign stall_mem    = w_d_any & ~r_d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scoreboard queue holds the memory transaction and
// response expected for each request; the memory side is driven inline.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        err;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err), .conflict_cnt(conflict_cnt)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_fetch(input logic [31:0] addr, input logic [31:0] rdata);
    exp_t e;
    if_req  = 1'b1;
    if_addr = addr;
    e = '{is_d: 1'b0, we: 1'b0, addr: addr, wdata: '0, rdata: rdata};
    sb.push_back(e);
  endtask

  task automatic req_data(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t e;
    d_read  = rd;
    d_write = wr;
    d_addr  = addr;
    d_wdata = wdata;
    e = '{is_d: 1'b1, we: wr, addr: addr, wdata: wdata, rdata: rdata};
    sb.push_back(e);
  endtask

  // Serve the oldest expected transaction: wait for mem_req, check it, ack after
  // 'delay' extra cycles, then check the ready pulse and its single-cycle width.
  task automatic serve(input int delay);
    exp_t e;
    int   n;
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    n = 0;
    step();
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    check("req_seen", 32'(mem_req), 32'd1);
    check("req_addr", mem_addr, e.addr);
    check("req_we", 32'(mem_we), 32'(e.we));
    if (e.we) check("req_wdata", mem_wdata, e.wdata);
    if (e.is_d) check("stall_mem_busy", 32'(stall_mem), 32'd1);
    else        check("stall_if_busy", 32'(stall_if), 32'd1);
    for (int i = 0; i < delay; i++) begin
      step();
      check("req_hold", {mem_req, mem_we, mem_addr[29:0]}, {1'b1, e.we, e.addr[29:0]});
    end
    mem_ack   = 1'b1;
    mem_rdata = e.rdata;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("req_drop", 32'(mem_req), 32'd0);
    if (e.is_d) begin
      check("d_ready_pulse", {if_ready, d_ready}, 32'b01);
      if (!e.we) check("d_rdata", d_rdata, e.rdata);
      check("stall_mem_rdy", 32'(stall_mem), 32'd0);
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      check("if_ready_pulse", {if_ready, d_ready}, 32'b10);
      check("if_rdata", if_rdata, e.rdata);
      check("stall_if_rdy", 32'(stall_if), 32'd0);
      if_req = 1'b0;
    end
    step();
    check("ready_clear", {if_ready, d_ready}, 32'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    int reqs;
    int consec;
    int overlap;
    logic prev_rdy;

    // Reset values
    step();
    step();
    check("rst_outs", {mem_req, mem_we, if_ready, d_ready, err}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", if_rdata | d_rdata, 32'd0);
    check("rst_conflict", 32'(conflict_cnt), 32'd0);
    reset = 1'b1;
    step();

    // Single fetch, ack one cycle after mem_req
    req_fetch(32'h40, 32'h8C220004);
    serve(1);

    // Simultaneous data write and fetch: data first, then fetch
    req_data(1'b0, 1'b1, 32'h100, 32'h55, 32'h0);
    req_fetch(32'h44, 32'h00A51020);
    serve(0);
    serve(0);
    check("conflict_one", 32'(conflict_cnt), 32'd1);

    // Held fetch with immediate-ack memory: one pulse every three cycles
    if_req    = 1'b1;
    if_addr   = 32'h80;
    pulses    = 0;
    reqs      = 0;
    consec    = 0;
    overlap   = 0;
    prev_rdy  = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (if_ready) begin
        pulses++;
        check("t5_rdata", if_rdata, 32'h12340080);
      end
      if (if_ready && prev_rdy) consec++;
      if (if_ready && mem_req) overlap++;
      if (mem_req) reqs++;
      prev_rdy  = if_ready;
      mem_ack   = mem_req;
      mem_rdata = 32'h12340080;
      if (k == 12) if_req = 1'b0;
    end
    mem_ack = 1'b0;
    check("t5_pulses", 32'(pulses), 32'd4);
    check("t5_reqs", 32'(reqs), 32'd4);
    check("t5_consec", 32'(consec), 32'd0);
    check("t5_overlap", 32'(overlap), 32'd0);
    check("err_clean", 32'(err), 32'd0);

    // Timeout on a data read
    d_read = 1'b1;
    d_addr = 32'h300;
    n = 0;
    step();
    while (mem_req && n < 40) begin
      n++;
      step();
    end
    check("to_wait_cycles", 32'(n), 32'd16);
    check("to_req_drop", 32'(mem_req), 32'd0);
    check("to_ready", 32'(d_ready), 32'd1);
    check("to_rdata", d_rdata, 32'hDEADBEEF);
    check("to_err", 32'(err), 32'd1);
    d_read = 1'b0;
    step();
    check("to_ready_clear", 32'(d_ready), 32'd0);
    req_fetch(32'h48, 32'h11112222);
    serve(2);
    check("err_sticky", 32'(err), 32'd1);

    // Reset in the middle of a data transaction
    d_read = 1'b1;
    d_addr = 32'h400;
    step();
    check("mid_req_up", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_ready", 32'(d_ready), 32'd0);
    check("mid_rst_conflict", 32'(conflict_cnt), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    d_read = 1'b0;
    step();
    step();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("mid_no_ready", {d_ready, mem_req}, 32'd0);
    end

    // Read and write together resolve to a write and flag err
    req_data(1'b1, 1'b1, 32'h200, 32'hAA, 32'h0);
    serve(0);
    check("rw_err", 32'(err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
